// File: rtl/cpu_axi_bridge_mo.sv
// SRAM-like inst/data ports to a single AXI3 master with multiple outstanding reads
// per port, keyed by AXI ID. Data writes are single-beat and serialised against data reads.
module cpu_axi_bridge_mo #(
  parameter int         RD_DEPTH = 4,
  parameter logic [3:0] INST_ID  = 4'd0,
  parameter logic [3:0] DATA_ID  = 4'd1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [3:0] DEPTH = 4'(RD_DEPTH);

  // Size code 3 has no AXI single-beat meaning on a 32-bit bus; fold it onto a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << offset;
  endfunction

  logic [3:0] inst_cnt;
  logic [3:0] data_cnt;
  logic       wr_busy;

  logic       ar_free;
  logic       data_rd_ok;
  logic       data_wr_ok;
  logic       inst_rd_ok;
  logic       inst_ret;
  logic       data_ret;
  logic       b_hit;

  assign ar_free    = !arvalid;
  assign data_rd_ok = data_req && !data_wr && ar_free && (data_cnt < DEPTH) && !wr_busy;
  assign inst_rd_ok = inst_req && ar_free && (inst_cnt < DEPTH) && !data_rd_ok;
  assign data_wr_ok = data_req && data_wr && !wr_busy && (data_cnt == 4'd0);

  assign inst_ret = rvalid && (rid == INST_ID);
  assign data_ret = rvalid && (rid == DATA_ID);
  assign b_hit    = bvalid && (bid == DATA_ID) && wr_busy && !awvalid && !wvalid;

  assign inst_addr_ok = inst_rd_ok;
  assign data_addr_ok = data_rd_ok || data_wr_ok;
  assign inst_data_ok = inst_ret;
  assign data_data_ok = data_ret || b_hit;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign rready  = 1'b1;
  assign bready  = 1'b1;
  assign wlast   = 1'b1;
  assign wid     = DATA_ID;
  assign awid    = DATA_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;

  logic unused_ok;
  assign unused_ok = ^{rresp, bresp};

  // AR slot: one request latched at a time, held stable until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid <= 1'b0;
      arid    <= 4'd0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else if (data_rd_ok) begin
      arvalid <= 1'b1;
      arid    <= DATA_ID;
      araddr  <= data_addr;
      arsize  <= {1'b0, norm_size(data_size)};
    end else if (inst_rd_ok) begin
      arvalid <= 1'b1;
      arid    <= INST_ID;
      araddr  <= inst_addr;
      arsize  <= {1'b0, norm_size(inst_size)};
    end else if (arvalid && arready) begin
      arvalid <= 1'b0;
    end
  end

  // Outstanding-read counters: an accept and a final beat in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_cnt <= 4'd0;
      data_cnt <= 4'd0;
    end else begin
      if (inst_rd_ok && !(inst_ret && rlast))
        inst_cnt <= inst_cnt + 4'd1;
      else if (!inst_rd_ok && inst_ret && rlast && inst_cnt != 4'd0)
        inst_cnt <= inst_cnt - 4'd1;

      if (data_rd_ok && !(data_ret && rlast))
        data_cnt <= data_cnt + 4'd1;
      else if (!data_rd_ok && data_ret && rlast && data_cnt != 4'd0)
        data_cnt <= data_cnt - 4'd1;
    end
  end

  // Write channel: AW and W retire independently; B closes the transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_busy <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
    end else begin
      if (data_wr_ok) begin
        wr_busy <= 1'b1;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= data_addr;
        awsize  <= {1'b0, norm_size(data_size)};
        wdata   <= data_wdata;
        wstrb   <= byte_strobe(norm_size(data_size), data_addr[1:0]);
      end else begin
        if (awvalid && awready) awvalid <= 1'b0;
        if (wvalid && wready)   wvalid  <= 1'b0;
        if (b_hit)              wr_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge_mo.sv
// Directed bench for cpu_axi_bridge_mo: the bench plays both the CPU and the AXI slave.
module tb_cpu_axi_bridge_mo;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge_mo #(.RD_DEPTH(4), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 0; inst_size = 2'd2; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

    tick(); tick();
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 1);
    chk("rst_bready", bready, 1);
    chk("rst_wlast", wlast, 1);
    chk("rst_wid", wid, 1);
    chk("rst_arburst", arburst, 2'b01);
    reset = 1'b0;
    tick();

    // 1: single inst read
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
    #1 chk("t1_addr_ok", inst_addr_ok, 1);
    tick(); inst_req = 0;
    #1;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'hBFC00000);
    chk("t1_arsize", arsize, 3'd2);
    chk("t1_arid", arid, 0);
    arready = 1;
    tick(); arready = 0;
    #1 chk("t1_ar_drop", arvalid, 0);
    rvalid = 1; rid = 0; rdata = 32'h3C1D0000;
    #1;
    chk("t1_data_ok", inst_data_ok, 1);
    chk("t1_rdata", inst_rdata, 32'h3C1D0000);
    chk("t1_no_data_ok", data_data_ok, 0);
    tick(); rvalid = 0;

    // 2: fill the inst read depth with R stalled
    arready = 1;
    for (int i = 0; i < 4; i++) begin
      inst_req = 1; inst_addr = 32'h1000 + 32'(i * 4);
      #1 chk("t2_accept", inst_addr_ok, 1);
      tick(); inst_req = 0;
      #1 chk("t2_slot_busy", inst_addr_ok, 0);
      chk("t2_araddr", araddr, 32'h1000 + 32'(i * 4));
      tick();
    end
    inst_req = 1; inst_addr = 32'h1010;
    #1 chk("t2_full", inst_addr_ok, 0);
    tick();
    #1 chk("t2_full_hold", inst_addr_ok, 0);
    rvalid = 1; rid = 0; rdata = 32'hD0D0_0000;
    #1 chk("t2_ret0", inst_rdata, 32'hD0D0_0000);
    chk("t2_ret0_ok", inst_data_ok, 1);
    tick(); rvalid = 0;
    #1 chk("t2_fifth_accept", inst_addr_ok, 1);
    tick(); inst_req = 0;
    #1 chk("t2_fifth_araddr", araddr, 32'h1010);
    tick();
    for (int i = 1; i < 5; i++) begin
      rvalid = 1; rid = 0; rdata = 32'hD0D0_0000 + 32'(i);
      #1 chk("t2_ret_ok", inst_data_ok, 1);
      chk("t2_ret_data", inst_rdata, 32'hD0D0_0000 + 32'(i));
      tick();
    end
    rvalid = 0;

    // 3: data read beats simultaneous inst read
    inst_req = 1; inst_addr = 32'h3000;
    data_req = 1; data_wr = 0; data_addr = 32'h2000; data_size = 2'd2;
    #1;
    chk("t3_data_ok", data_addr_ok, 1);
    chk("t3_inst_blocked", inst_addr_ok, 0);
    tick(); data_req = 0;
    #1;
    chk("t3_arid", arid, 1);
    chk("t3_araddr", araddr, 32'h2000);
    chk("t3_inst_wait", inst_addr_ok, 0);
    tick();
    #1 chk("t3_inst_accept", inst_addr_ok, 1);
    tick(); inst_req = 0;
    #1 chk("t3_inst_arid", arid, 0);
    chk("t3_inst_araddr", araddr, 32'h3000);
    tick();
    rvalid = 1; rid = 1; rdata = 32'h2222_2222;
    #1 chk("t3_dret", data_data_ok, 1);
    chk("t3_dret_inst", inst_data_ok, 0);
    chk("t3_drdata", data_rdata, 32'h2222_2222);
    tick();
    rid = 0; rdata = 32'h3333_3333;
    #1 chk("t3_iret", inst_data_ok, 1);
    chk("t3_iret_data", data_data_ok, 0);
    tick(); rvalid = 0;

    // 4: byte write at offset 3, W before AW, inst read overlapping
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h8000_0003; data_wdata = 32'hAB;
    #1 chk("t4_accept", data_addr_ok, 1);
    tick(); data_req = 0; data_wr = 0;
    #1;
    chk("t4_awvalid", awvalid, 1);
    chk("t4_wvalid", wvalid, 1);
    chk("t4_wstrb", wstrb, 4'b1000);
    chk("t4_awsize", awsize, 3'd0);
    chk("t4_awaddr", awaddr, 32'h8000_0003);
    chk("t4_wdata", wdata, 32'hAB);
    chk("t4_awid", awid, 1);
    inst_req = 1; inst_addr = 32'h4000; wready = 1;
    #1 chk("t4_inst_overlap", inst_addr_ok, 1);
    tick(); inst_req = 0; wready = 0;
    #1 chk("t4_w_done", wvalid, 0);
    chk("t4_aw_hold", awvalid, 1);
    chk("t4_inst_ar", arvalid, 1);
    tick();
    rvalid = 1; rid = 0; rdata = 32'h4444_4444;
    #1 chk("t4_inst_ret", inst_data_ok, 1);
    chk("t4_no_dok", data_data_ok, 0);
    tick(); rvalid = 0;
    awready = 1;
    #1 chk("t4_aw_before", awvalid, 1);
    tick(); awready = 0;
    #1 chk("t4_aw_done", awvalid, 0);
    data_req = 1; data_wr = 0; data_addr = 32'h5000; data_size = 2'd2;
    #1 chk("t4_rd_blocked", data_addr_ok, 0);
    chk("t4_pre_b", data_data_ok, 0);
    data_req = 0;
    bvalid = 1; bid = 1;
    #1 chk("t4_b_ok", data_data_ok, 1);
    tick(); bvalid = 0;
    #1 chk("t4_b_once", data_data_ok, 0);

    // 5: write waits for outstanding data read
    data_req = 1; data_wr = 0; data_addr = 32'h6000; data_size = 2'd2;
    #1 chk("t5_rd_accept", data_addr_ok, 1);
    tick(); data_req = 0;
    tick();
    data_req = 1; data_wr = 1; data_addr = 32'h7000; data_size = 2'd3; data_wdata = 32'h11223344;
    #1 chk("t5_wr_blocked", data_addr_ok, 0);
    tick();
    #1 chk("t5_wr_blocked2", data_addr_ok, 0);
    rvalid = 1; rid = 1; rdata = 32'h6666_6666;
    #1 chk("t5_rd_ret", data_data_ok, 1);
    chk("t5_wr_still", data_addr_ok, 0);
    tick(); rvalid = 0;
    #1 chk("t5_wr_accept", data_addr_ok, 1);
    tick(); data_req = 0; data_wr = 0;
    #1 chk("t5_awsize", awsize, 3'd2);
    chk("t5_wstrb", wstrb, 4'b1111);
    awready = 1; wready = 1;
    tick(); awready = 0; wready = 0;
    bvalid = 1; bid = 1;
    #1 chk("t5_b_ok", data_data_ok, 1);
    tick(); bvalid = 0;

    // 6: reset mid-operation
    arready = 0;
    inst_req = 1; inst_addr = 32'h8000;
    data_req = 1; data_wr = 1; data_addr = 32'h9000; data_size = 2'd2;
    #1 chk("t6_inst_ok", inst_addr_ok, 1);
    chk("t6_data_ok", data_addr_ok, 1);
    tick(); inst_req = 0; data_req = 0; data_wr = 0;
    #1 chk("t6_arvalid", arvalid, 1);
    chk("t6_awvalid", awvalid, 1);
    reset = 1;
    tick(); reset = 0;
    #1 chk("t6_rst_ar", arvalid, 0);
    chk("t6_rst_aw", awvalid, 0);
    chk("t6_rst_w", wvalid, 0);
    tick();
    data_req = 1; data_wr = 0; data_addr = 32'hA000;
    #1 chk("t6_post_accept", data_addr_ok, 1);
    tick(); data_req = 0;
    #1 chk("t6_post_arid", arid, 1);
    chk("t6_post_araddr", araddr, 32'hA000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge_mo.md
Name: cpu_axi_bridge_mo

Overview:
Parametrised successor to the sram-like-to-AXI bridge. Converts the inst port (read-only) and data port (read/write) to one AXI3 master. Allows up to RD_DEPTH outstanding reads per port, keyed by AXI ID. Inst reads overlap a pending data write. Sits between the CPU core and the AXI crossbar.

Parameters:
RD_DEPTH, 4, max outstanding reads per port (1..15)
INST_ID, 4'd0, arid used for inst reads
DATA_ID, 4'd1, arid/awid/wid used for data accesses

Ports:
clk  in  1  clock
reset  in  1  synchronous reset; decided: one clock, reset synchronous active-high
inst_req / inst_size / inst_addr  in  1/2/32  inst read request; size 0=1B 1=2B 2=4B
inst_rdata / inst_addr_ok / inst_data_ok  out  32/1/1  inst response
data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  data request; wr=1 means write
data_rdata / data_addr_ok / data_data_ok  out  32/1/1  data response
arid, araddr, arsize, arvalid  out  4/32/3/1;  arready  in  1
rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1;  rready  out  1
awid, awaddr, awsize, awvalid  out  4/32/3/1;  awready  in  1
wid, wdata, wstrb, wlast, wvalid  out  4/32/4/1/1;  wready  in  1
bid, bresp, bvalid  in  4/2/1;  bready  out  1
arlen/awlen, arburst/awburst, arlock/awlock, arcache/awcache, arprot/awprot  out  8/2/2/4/3 each  constants 0, 2'b01, 0, 0, 0

Behaviour:
- Reset: arvalid=awvalid=wvalid=0. inst_cnt=data_cnt=0. wr_busy=0. All other registers 0. rready=bready=1 at all times, including during reset. wlast=1, wid=DATA_ID. rresp/bresp ignored.
- Size: data_size/inst_size 3 is treated as 2. arsize/awsize = {1'b0, size}. wstrb = (size0: 4'b0001, size1: 4'b0011, size2: 4'b1111) << addr[1:0]. Addresses pass through unaligned-unchanged.
- AR slot: free when arvalid=0.
  - Data read eligible when data_req & !data_wr & slot free & data_cnt<RD_DEPTH & !wr_busy.
  - Inst read eligible when inst_req & slot free & inst_cnt<RD_DEPTH & no data read eligible. Data has fixed priority.
- addr_ok is combinational and equals eligibility in the same cycle. On accept, next cycle: arvalid=1 with latched araddr, arsize and arid. arvalid holds stable until arready, then drops. Minimum 2 cycles per AR.
- Counters:
  - Port cnt +1 on accept.
  - cnt -1 on rvalid & rlast with matching rid.
  - Both in the same cycle: cnt unchanged.
- Read return:
  - inst_data_ok = rvalid & rid==INST_ID.
  - data_data_ok read term = rvalid & rid==DATA_ID.
  - inst_rdata = data_rdata = rdata, combinational.
  - Other rid values are consumed and ignored.
- Write: data_addr_ok for a write = data_req & data_wr & !wr_busy & data_cnt==0.
  - On accept: wr_busy=1; latch awaddr, awsize, wdata, wstrb. Next cycle awvalid=wvalid=1.
  - Each valid drops independently on its own handshake. W may complete before AW and vice versa.
  - wr_busy clears on bvalid & bid==DATA_ID, after both handshakes. data_data_ok write term = that bvalid.
- Ordering: the data port never has a read and a write outstanding together. This keeps data_data_ok in request order and prevents RAW hazards. Read and write terms can never assert in the same cycle.
- Inst reads may be issued and returned while wr_busy=1.
- Back-to-back data reads: data_cnt reaching RD_DEPTH drops data_addr_ok until a return arrives. An accept and a return in the same cycle keep cnt at RD_DEPTH-1+1.
- Reset mid-operation clears all state and drops valids in the next cycle. Beats still in flight are discarded. The slave is reset together with the bridge.

Test Plan:
1. Reset, then inst_req addr 0xBFC00000 size 2 -> inst_addr_ok same cycle. Next cycle arvalid=1, araddr=0xBFC00000, arsize=2, arid=0. After rvalid rid=0 rdata=0x3C1D0000: inst_data_ok=1 with inst_rdata=0x3C1D0000.
2. RD_DEPTH=4, slave stalls R; issue 5 inst reads -> 4 accepted, 5th waits with inst_addr_ok=0. First R beat returns -> 5th accepted. Data returned in issue order.
3. inst_req and data read in the same cycle -> data wins with arid=1. Inst accepted once the AR slot frees.
4. Data write size 0, addr 0x...03, wdata 0x000000AB -> wstrb=4'b1000, awsize=0. wready precedes awready by 3 cycles. Exactly one data_data_ok on bvalid. Inst read issued mid-write completes before B.
5. Data read pending (data_cnt=1) with a data write requested -> data_addr_ok=0 until the read returns. Write then accepted.
6. Assert reset while arvalid=1 and wr_busy=1 -> next cycle all valids=0, counters=0. A new request is accepted normally after reset deasserts.
